// File: rtl/tpu_pkg.sv
// Shared defaults and element types for the systolic MAC array.
package tpu_pkg;

    localparam int BITS_AB_DEF = 8;
    localparam int BITS_C_DEF  = 16;
    localparam int DIM_DEF     = 8;

    typedef logic signed [BITS_AB_DEF-1:0] ab_t;
    typedef logic signed [BITS_C_DEF-1:0]  c_t;

endpackage

// File: rtl/systolic_array_if.sv
// Operand feed and host row-access bus of the systolic array.
interface systolic_array_if
    import tpu_pkg::*;
#(
    parameter int BITS_AB = BITS_AB_DEF,
    parameter int BITS_C  = BITS_C_DEF,
    parameter int DIM     = DIM_DEF
);

    logic                      en;
    logic                      WrEn;
    logic signed [BITS_AB-1:0] Ain  [DIM];
    logic signed [BITS_AB-1:0] Bin  [DIM];
    logic [$clog2(DIM)-1:0]    Crow;
    logic signed [BITS_C-1:0]  Cin  [DIM];
    logic signed [BITS_C-1:0]  Cout [DIM];

    modport master (
        output en, WrEn, Ain, Bin, Crow, Cin,
        input  Cout
    );

    modport slave (
        input  en, WrEn, Ain, Bin, Crow, Cin,
        output Cout
    );

endinterface

// File: rtl/tpumac.sv
// One output-stationary MAC cell: registered A/B pass-through plus a C accumulator.
module tpumac
    import tpu_pkg::*;
#(
    parameter int BITS_AB = BITS_AB_DEF,
    parameter int BITS_C  = BITS_C_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      WrEn,
    input  logic signed [BITS_AB-1:0] Ain,
    input  logic signed [BITS_AB-1:0] Bin,
    input  logic signed [BITS_C-1:0]  Cin,
    output logic signed [BITS_AB-1:0] Aout,
    output logic signed [BITS_AB-1:0] Bout,
    output logic signed [BITS_C-1:0]  Cout
);

    logic signed [BITS_AB-1:0]   a_q, a_d;
    logic signed [BITS_AB-1:0]   b_q, b_d;
    logic signed [BITS_C-1:0]    c_q, c_d;
    logic signed [2*BITS_AB-1:0] prod;

    // Accumulate the incoming operands, not the registered ones; a host write wins over accumulation.
    always_comb begin
        prod = Ain * Bin;
        a_d  = a_q;
        b_d  = b_q;
        c_d  = c_q;
        if (en) begin
            a_d = Ain;
            b_d = Bin;
            c_d = c_q + BITS_C'(prod);
        end
        if (WrEn) begin
            c_d = Cin;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
            c_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
            c_q <= c_d;
        end
    end

    assign Aout = a_q;
    assign Bout = b_q;
    assign Cout = c_q;

endmodule

// File: rtl/systolic_array.sv
// DIM x DIM grid of tpumac cells with left/top operand edges and a row-select C port.
module systolic_array
    import tpu_pkg::*;
#(
    parameter int BITS_AB = BITS_AB_DEF,
    parameter int BITS_C  = BITS_C_DEF,
    parameter int DIM     = DIM_DEF
) (
    input logic             clk,
    input logic             rst,
    systolic_array_if.slave bus
);

    localparam int CROW_W = $clog2(DIM);

    logic signed [BITS_AB-1:0] a_out [DIM][DIM];
    logic signed [BITS_AB-1:0] b_out [DIM][DIM];
    logic signed [BITS_C-1:0]  c_all [DIM][DIM];

    for (genvar r = 0; r < DIM; r++) begin : g_row
        logic row_wr;
        assign row_wr = bus.WrEn && (bus.Crow == CROW_W'(r));

        for (genvar c = 0; c < DIM; c++) begin : g_col
            logic signed [BITS_AB-1:0] a_in;
            logic signed [BITS_AB-1:0] b_in;

            // Edge cells take the feeder operands; interior cells take the neighbour's registers.
            if (c == 0) begin : g_a_edge
                assign a_in = bus.Ain[r];
            end else begin : g_a_link
                assign a_in = a_out[r][c-1];
            end

            if (r == 0) begin : g_b_edge
                assign b_in = bus.Bin[c];
            end else begin : g_b_link
                assign b_in = b_out[r-1][c];
            end

            tpumac #(
                .BITS_AB (BITS_AB),
                .BITS_C  (BITS_C)
            ) u_mac (
                .clk  (clk),
                .rst  (rst),
                .en   (bus.en),
                .WrEn (row_wr),
                .Ain  (a_in),
                .Bin  (b_in),
                .Cin  (bus.Cin[c]),
                .Aout (a_out[r][c]),
                .Bout (b_out[r][c]),
                .Cout (c_all[r][c])
            );
        end
    end

    always_comb begin
        for (int unsigned c = 0; c < DIM; c++) begin
            bus.Cout[c] = c_all[bus.Crow][c];
        end
    end

endmodule

// File: tb/tb_systolic_array.sv
// Directed bench for a 4x4 systolic_array: vector table plus multi-cycle sequences.
module tb_systolic_array;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    systolic_array_if #(.BITS_AB(8), .BITS_C(16), .DIM(4)) bus ();

    systolic_array #(
        .BITS_AB (8),
        .BITS_C  (16),
        .DIM     (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic             en;
        logic             wr;
        logic [1:0]       crow;
        logic [3:0][7:0]  ain;
        logic [3:0][7:0]  bin;
        logic [3:0][15:0] cin;
        logic [1:0]       chk;
        logic [3:0][15:0] exp;
    } vec_t;

    localparam int NV = 10;
    vec_t vt [NV];

    function automatic logic [3:0][7:0] r8(input int x0, input int x1, input int x2, input int x3);
        logic [3:0][7:0] v;
        v[0] = 8'(x0); v[1] = 8'(x1); v[2] = 8'(x2); v[3] = 8'(x3);
        return v;
    endfunction

    function automatic logic [3:0][15:0] r16(input int x0, input int x1, input int x2, input int x3);
        logic [3:0][15:0] v;
        v[0] = 16'(x0); v[1] = 16'(x1); v[2] = 16'(x2); v[3] = 16'(x3);
        return v;
    endfunction

    function automatic vec_t mkv(input logic en, input logic wr, input int crow,
                                 input logic [3:0][7:0] a, input logic [3:0][7:0] b,
                                 input logic [3:0][15:0] cin, input int chk,
                                 input logic [3:0][15:0] exp);
        vec_t v;
        v.en = en; v.wr = wr; v.crow = 2'(crow);
        v.ain = a; v.bin = b; v.cin = cin;
        v.chk = 2'(chk); v.exp = exp;
        return v;
    endfunction

    task automatic apply(input logic en, input logic wr, input int crow,
                         input logic [3:0][7:0] a, input logic [3:0][7:0] b,
                         input logic [3:0][15:0] cin);
        bus.en   = en;
        bus.WrEn = wr;
        bus.Crow = 2'(crow);
        for (int i = 0; i < 4; i++) begin
            bus.Ain[i] = a[i];
            bus.Bin[i] = b[i];
            bus.Cin[i] = cin[i];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        bus.en   = 1'b0;
        bus.WrEn = 1'b0;
    endtask

    task automatic check_row(input string name, input int row, input logic [3:0][15:0] exp);
        logic bad;
        bus.Crow = 2'(row);
        #1;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (bus.Cout[i] !== exp[i]) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL %s row%0d got {%0d,%0d,%0d,%0d} expected {%0d,%0d,%0d,%0d}", name, row,
                     bus.Cout[0], bus.Cout[1], bus.Cout[2], bus.Cout[3],
                     $signed(exp[0]), $signed(exp[1]), $signed(exp[2]), $signed(exp[3]));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    // Skewed identity x B feed; optional 5-cycle en=0 gap with junk operands before cycle freeze_at.
    task automatic run_mm(input int freeze_at);
        logic [3:0][7:0] a;
        logic [3:0][7:0] b;
        for (int t = 0; t < 10; t++) begin
            if (t == freeze_at) begin
                for (int f = 0; f < 5; f++) begin
                    apply(1'b0, 1'b0, 0, r8(77, -55, 33, -11), r8(-66, 44, -22, 11), r16(1, 2, 3, 4));
                    tick();
                end
            end
            for (int i = 0; i < 4; i++) begin
                int k;
                k = t - i;
                a[i] = (k == i) ? 8'd1 : 8'd0;
                b[i] = (k >= 0 && k < 4) ? 8'(4 * k + i + 1) : 8'd0;
            end
            apply(1'b1, 1'b0, 0, a, b, r16(0, 0, 0, 0));
            tick();
        end
    endtask

    logic [3:0][7:0]  z8;
    logic [3:0][15:0] z16;

    initial begin
        checks = 0;
        errors = 0;
        z8  = r8(0, 0, 0, 0);
        z16 = r16(0, 0, 0, 0);

        vt[0] = mkv(1, 0, 0, r8(3, 0, 0, 0), r8(-2, 0, 0, 0), z16, 0, r16(-6, 0, 0, 0));
        vt[1] = mkv(1, 0, 0, z8, z8, z16, 0, r16(-6, 0, 0, 0));
        vt[2] = mkv(1, 0, 0, z8, z8, z16, 1, z16);
        vt[3] = mkv(1, 0, 0, z8, z8, z16, 0, r16(-6, 0, 0, 0));
        vt[4] = mkv(0, 1, 0, r8(9, 9, 9, 9), r8(9, 9, 9, 9), r16(100, -100, 32767, -32768),
                    0, r16(100, -100, 32767, -32768));
        vt[5] = mkv(0, 0, 0, r8(9, 9, 9, 9), r8(9, 9, 9, 9), z16, 0, r16(100, -100, 32767, -32768));
        vt[6] = mkv(0, 1, 0, z8, z8, z16, 0, z16);
        vt[7] = mkv(1, 0, 0, r8(127, 0, 0, 0), r8(127, 0, 0, 0), z16, 0, r16(16129, 0, 0, 0));
        vt[8] = mkv(1, 0, 0, r8(127, 0, 0, 0), r8(127, 0, 0, 0), z16, 0, r16(32258, 0, 0, 0));
        vt[9] = mkv(1, 0, 0, r8(127, 0, 0, 0), r8(127, 0, 0, 0), z16, 0, r16(-17149, 0, 0, 0));

        rst = 1'b1;
        apply(1'b0, 1'b0, 0, z8, z8, z16);
        for (int r = 0; r < 4; r++) check_row("reset", r, z16);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            apply(vt[i].en, vt[i].wr, int'(vt[i].crow), vt[i].ain, vt[i].bin, vt[i].cin);
            tick();
            check_row($sformatf("vec%0d", i), int'(vt[i].chk), vt[i].exp);
        end

        do_reset();
        for (int k = 1; k <= 4; k++) begin
            apply(1'b1, k == 4, 2, r8(1, 2, 3, 4), r8(5, 6, 7, 8), r16(5, 6, 7, 8));
            tick();
        end
        check_row("wrprio", 0, r16(20, 18, 14, 8));
        check_row("wrprio", 1, r16(30, 36, 28, 16));
        check_row("wrprio", 2, r16(5, 6, 7, 8));
        check_row("wrprio", 3, r16(20, 24, 28, 32));

        apply(1'b0, 1'b1, 1, r8(1, 2, 3, 4), r8(5, 6, 7, 8), r16(-1, -2, -3, -4));
        check_row("read_old", 1, r16(30, 36, 28, 16));
        tick();
        check_row("wr_noen", 1, r16(-1, -2, -3, -4));
        check_row("wr_noen", 0, r16(20, 18, 14, 8));

        apply(1'b1, 1'b0, 0, r8(1, 2, 3, 4), r8(5, 6, 7, 8), z16);
        tick();
        check_row("post_wr", 0, r16(25, 24, 21, 16));
        check_row("post_wr", 1, r16(9, 10, 11, 12));
        check_row("post_wr", 2, r16(20, 24, 28, 32));
        check_row("post_wr", 3, r16(40, 48, 56, 64));

        do_reset();
        run_mm(-1);
        for (int r = 0; r < 4; r++)
            check_row("mm", r, r16(4 * r + 1, 4 * r + 2, 4 * r + 3, 4 * r + 4));

        do_reset();
        run_mm(4);
        for (int r = 0; r < 4; r++)
            check_row("mm_freeze", r, r16(4 * r + 1, 4 * r + 2, 4 * r + 3, 4 * r + 4));

        @(posedge clk);
        #3;
        rst = 1'b1;
        for (int r = 0; r < 4; r++) check_row("async_rst", r, z16);
        @(negedge clk);
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
